// File: rtl/smartlift_pkg.sv
// Shared encodings and helpers for the smartlift floor scheduler.
package smartlift_pkg;
    localparam int NFLOORS_DEF = 9;
    localparam int FLOOR_W_DEF = 4;

    // Numeric values match the LCD's parado/subindo/descendo texts.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2,
        ST_DOOR = 2'd3
    } state_t;

    function automatic logic onehot_valid(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction
endpackage

// File: rtl/smartlift_req_scan.sv
// Finds whether calls are pending above/below the car and the nearest one each way.
module smartlift_req_scan
    import smartlift_pkg::*;
#(
    parameter int NFLOORS = NFLOORS_DEF,
    parameter int FLOOR_W = FLOOR_W_DEF
) (
    input  logic [NFLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0] cur_floor,
    output logic               any_above,
    output logic               any_below,
    output logic [FLOOR_W-1:0] near_above,
    output logic [FLOOR_W-1:0] near_below
);
    always_comb begin
        any_above  = 1'b0;
        any_below  = 1'b0;
        near_above = cur_floor;
        near_below = cur_floor;
        // Scan from the far end so the last hit is the nearest one.
        for (int i = NFLOORS - 1; i >= 0; i--) begin
            if (pending[i] && (i > int'(cur_floor))) begin
                any_above  = 1'b1;
                near_above = FLOOR_W'(i);
            end
        end
        for (int i = 0; i < NFLOORS; i++) begin
            if (pending[i] && (i < int'(cur_floor))) begin
                any_below  = 1'b1;
                near_below = FLOOR_W'(i);
            end
        end
    end
endmodule

// File: rtl/smartlift_scheduler.sv
// SCAN-order elevator scheduler; states: IDLE parked | UP rising | DOWN falling | DOOR dwell.
module smartlift_scheduler
    import smartlift_pkg::*;
#(
    parameter int NFLOORS     = NFLOORS_DEF,
    parameter int FLOOR_W     = FLOOR_W_DEF,
    parameter int FLOOR_TICKS = 2,
    parameter int DOOR_TICKS  = 3
) (
    input  logic               CLOCK_50,
    input  logic               RESET,
    input  logic               tick,
    input  logic               req_strobe,
    input  logic [NFLOORS-1:0] req_onehot,
    output logic [FLOOR_W-1:0] cur_floor,
    output logic [FLOOR_W-1:0] target_floor,
    output logic [1:0]         state,
    output logic [NFLOORS-1:0] pending,
    output logic               door_open,
    output logic               state_changed,
    output logic               req_err
);
    localparam int CNT_MAX = (FLOOR_TICKS > DOOR_TICKS) ? FLOOR_TICKS : DOOR_TICKS;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    state_t             state_q, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [FLOOR_W-1:0] floor_nxt, new_floor;
    logic [NFLOORS-1:0] pending_nxt;
    logic               dir_up, dir_nxt, err_nxt;
    logic               req_ok, req_here, stationary, hit, beyond;
    logic               any_above, any_below;
    logic [FLOOR_W-1:0] near_above, near_below;

    smartlift_req_scan #(.NFLOORS(NFLOORS), .FLOOR_W(FLOOR_W)) u_scan (
        .pending    (pending),
        .cur_floor  (cur_floor),
        .any_above  (any_above),
        .any_below  (any_below),
        .near_above (near_above),
        .near_below (near_below)
    );

    assign req_ok     = req_strobe && onehot_valid(32'(req_onehot));
    assign req_here   = req_ok && req_onehot[cur_floor];
    assign stationary = (state_q == ST_IDLE) || (state_q == ST_DOOR);

    always_comb begin
        state_nxt   = state_q;
        cnt_nxt     = cnt;
        floor_nxt   = cur_floor;
        dir_nxt     = dir_up;
        pending_nxt = pending;
        err_nxt     = req_strobe && !req_ok;
        new_floor   = cur_floor;
        hit         = 1'b0;
        beyond      = 1'b0;

        if (req_ok && !(req_here && stationary))
            pending_nxt = pending | req_onehot;

        if (tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (any_above && (dir_up || !any_below)) begin
                        state_nxt = ST_UP;
                        dir_nxt   = 1'b1;
                        cnt_nxt   = '0;
                    end else if (any_below) begin
                        state_nxt = ST_DOWN;
                        dir_nxt   = 1'b0;
                        cnt_nxt   = '0;
                    end
                end
                ST_UP, ST_DOWN: begin
                    if (cnt == CNT_W'(FLOOR_TICKS - 1)) begin
                        new_floor = (state_q == ST_UP) ? cur_floor + FLOOR_W'(1)
                                                       : cur_floor - FLOOR_W'(1);
                        floor_nxt = new_floor;
                        cnt_nxt   = '0;
                        // A strobe for the arrival floor counts as serviced here.
                        hit = pending[new_floor] || (req_ok && req_onehot[new_floor]);
                        pending_nxt[new_floor] = 1'b0;
                        for (int i = 0; i < NFLOORS; i++) begin
                            if (pending_nxt[i] && ((state_q == ST_UP) ? (i > int'(new_floor))
                                                                     : (i < int'(new_floor))))
                                beyond = 1'b1;
                        end
                        if (hit)
                            state_nxt = ST_DOOR;
                        else if (!beyond)
                            state_nxt = ST_IDLE;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    if (cnt == CNT_W'(DOOR_TICKS - 1)) begin
                        state_nxt = ST_IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            endcase
        end

        if (req_here && stationary) begin
            state_nxt = ST_DOOR;
            cnt_nxt   = '0;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state_q       <= ST_IDLE;
            cnt           <= '0;
            cur_floor     <= '0;
            dir_up        <= 1'b1;
            pending       <= '0;
            door_open     <= 1'b0;
            state_changed <= 1'b0;
            req_err       <= 1'b0;
        end else begin
            state_q       <= state_nxt;
            cnt           <= cnt_nxt;
            cur_floor     <= floor_nxt;
            dir_up        <= dir_nxt;
            pending       <= pending_nxt;
            door_open     <= (state_nxt == ST_DOOR);
            state_changed <= (state_nxt != state_q);
            req_err       <= err_nxt;
        end
    end

    always_comb begin
        target_floor = cur_floor;
        case (state_q)
            ST_UP:   if (any_above) target_floor = near_above;
            ST_DOWN: if (any_below) target_floor = near_below;
            default: begin
                if (any_above && (dir_up || !any_below))
                    target_floor = near_above;
                else if (any_below)
                    target_floor = near_below;
            end
        endcase
    end

    assign state = state_q;

    // Travel is only ever entered toward a pending call, so the car cannot run off either end.
    a_floor_range: assert property (@(posedge CLOCK_50) disable iff (RESET)
        int'(cur_floor) < NFLOORS);
    a_up_room: assert property (@(posedge CLOCK_50) disable iff (RESET)
        (state_q == ST_UP) |-> (int'(cur_floor) < NFLOORS - 1));
    a_down_room: assert property (@(posedge CLOCK_50) disable iff (RESET)
        (state_q == ST_DOWN) |-> (cur_floor != '0));
endmodule

// File: tb/tb_smartlift_scheduler.sv
// Self-checking bench: directed vector table, corner sequences and random traffic vs a model.
module tb_smartlift_scheduler;
    localparam int NF = 9;
    localparam int FW = 4;
    localparam int FT = 2;
    localparam int DT = 3;

    logic          CLOCK_50 = 1'b0;
    logic          RESET = 1'b1;
    logic          tick = 1'b0;
    logic          req_strobe = 1'b0;
    logic [NF-1:0] req_onehot = '0;
    logic [FW-1:0] cur_floor, target_floor;
    logic [1:0]    state;
    logic [NF-1:0] pending;
    logic          door_open, state_changed, req_err;

    smartlift_scheduler #(.NFLOORS(NF), .FLOOR_W(FW), .FLOOR_TICKS(FT), .DOOR_TICKS(DT)) dut (
        .CLOCK_50      (CLOCK_50),
        .RESET         (RESET),
        .tick          (tick),
        .req_strobe    (req_strobe),
        .req_onehot    (req_onehot),
        .cur_floor     (cur_floor),
        .target_floor  (target_floor),
        .state         (state),
        .pending       (pending),
        .door_open     (door_open),
        .state_changed (state_changed),
        .req_err       (req_err)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int total = 0;
    int bad = 0;

    // Reference model: floor as an int, calls as a bit set, timer counts ticks remaining.
    int          m_floor, m_state, m_left;
    bit          m_dirup, m_chg, m_err, m_door;
    bit [NF-1:0] m_pend;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_any(input bit [NF-1:0] p, input int fl, input bit above);
        for (int i = 0; i < NF; i++)
            if (p[i] && (above ? (i > fl) : (i < fl))) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_target();
        int lo_above = -1;
        int hi_below = -1;
        for (int i = 0; i < NF; i++) begin
            if (m_pend[i] && i > m_floor && lo_above < 0) lo_above = i;
            if (m_pend[i] && i < m_floor) hi_below = i;
        end
        if (m_state == 1) return (lo_above >= 0) ? lo_above : m_floor;
        if (m_state == 2) return (hi_below >= 0) ? hi_below : m_floor;
        if (lo_above >= 0 && (m_dirup || hi_below < 0)) return lo_above;
        if (hi_below >= 0) return hi_below;
        return m_floor;
    endfunction

    task automatic model_reset();
        m_floor = 0; m_state = 0; m_left = 0; m_dirup = 1'b1;
        m_pend = '0; m_chg = 1'b0; m_err = 1'b0; m_door = 1'b0;
    endtask

    task automatic model_step(input bit tk, input bit stb, input logic [NF-1:0] oh);
        int req, ns, nf, nl;
        bit valid, stationary, hit, nd;
        bit [NF-1:0] np;
        req = -1;
        for (int i = 0; i < NF; i++) if (oh[i]) req = i;
        valid = stb && ($countones(oh) == 1);
        stationary = (m_state == 0) || (m_state == 3);
        ns = m_state; nf = m_floor; nl = m_left; nd = m_dirup; np = m_pend;
        if (valid && !(req == m_floor && stationary)) np[req] = 1'b1;
        if (tk) begin
            case (m_state)
                0: begin
                    if (m_any(m_pend, m_floor, 1'b1) && (m_dirup || !m_any(m_pend, m_floor, 1'b0))) begin
                        ns = 1; nd = 1'b1; nl = FT;
                    end else if (m_any(m_pend, m_floor, 1'b0)) begin
                        ns = 2; nd = 1'b0; nl = FT;
                    end
                end
                1, 2: begin
                    nl = m_left - 1;
                    if (nl == 0) begin
                        nf = (m_state == 1) ? m_floor + 1 : m_floor - 1;
                        nl = FT;
                        hit = m_pend[nf] || (valid && req == nf);
                        np[nf] = 1'b0;
                        if (hit) begin
                            ns = 3; nl = DT;
                        end else if (!m_any(np, nf, m_state == 1)) begin
                            ns = 0;
                        end
                    end
                end
                default: begin
                    nl = m_left - 1;
                    if (nl == 0) ns = 0;
                end
            endcase
        end
        if (valid && req == m_floor && stationary) begin
            ns = 3; nl = DT;
        end
        m_chg = (ns != m_state);
        m_door = (ns == 3);
        m_err = stb && !valid;
        m_state = ns; m_floor = nf; m_left = nl; m_dirup = nd; m_pend = np;
    endtask

    task automatic model_check();
        check("state", 32'(state), 32'(m_state));
        check("cur_floor", 32'(cur_floor), 32'(m_floor));
        check("pending", 32'(pending), 32'(m_pend));
        check("door_open", 32'(door_open), 32'(m_door));
        check("state_changed", 32'(state_changed), 32'(m_chg));
        check("req_err", 32'(req_err), 32'(m_err));
        check("target_floor", 32'(target_floor), 32'(m_target()));
    endtask

    task automatic cycle(input bit tk, input bit stb, input logic [NF-1:0] oh);
        tick = tk; req_strobe = stb; req_onehot = oh;
        @(posedge CLOCK_50);
        model_step(tk, stb, oh);
        #1;
        tick = 1'b0; req_strobe = 1'b0; req_onehot = '0;
        model_check();
    endtask

    task automatic do_reset(input string name);
        #2;
        RESET = 1'b1;
        #1;
        model_reset();
        check({name, "_floor"}, 32'(cur_floor), 32'd0);
        check({name, "_state"}, 32'(state), 32'd0);
        check({name, "_pending"}, 32'(pending), 32'd0);
        @(posedge CLOCK_50);
        #1;
        RESET = 1'b0;
    endtask

    typedef struct {
        bit          tk;
        bit          stb;
        logic [NF-1:0] oh;
        int          st;
        int          fl;
        int          pd;
        bit          dr;
        bit          ch;
        bit          er;
        int          tg;
    } vec_t;

    vec_t vecs[17];
    int   stops[$];

    task automatic run_until_idle(input string name, output int dn_tgt);
        bit done = 1'b0;
        dn_tgt = -1;
        stops.delete();
        for (int k = 0; k < 200; k++) begin
            cycle(1'b1, 1'b0, '0);
            if (door_open && state_changed) stops.push_back(int'(cur_floor));
            if (state == 2'd2 && dn_tgt < 0) dn_tgt = int'(target_floor);
            if (state == 2'd0 && pending == '0) begin
                done = 1'b1;
                break;
            end
        end
        check({name, "_finished"}, 32'(done), 32'd1);
    endtask

    initial begin
        int s0, s1, dn_tgt;
        bit ok;
        logic [NF-1:0] oh;

        vecs[0]  = '{1'b0, 1'b1, 9'h008, 0, 0, 8, 1'b0, 1'b0, 1'b0, 3};
        vecs[1]  = '{1'b1, 1'b0, 9'h000, 1, 0, 8, 1'b0, 1'b1, 1'b0, 3};
        vecs[2]  = '{1'b0, 1'b0, 9'h000, 1, 0, 8, 1'b0, 1'b0, 1'b0, 3};
        vecs[3]  = '{1'b1, 1'b0, 9'h000, 1, 0, 8, 1'b0, 1'b0, 1'b0, 3};
        vecs[4]  = '{1'b1, 1'b0, 9'h000, 1, 1, 8, 1'b0, 1'b0, 1'b0, 3};
        vecs[5]  = '{1'b1, 1'b0, 9'h000, 1, 1, 8, 1'b0, 1'b0, 1'b0, 3};
        vecs[6]  = '{1'b1, 1'b0, 9'h000, 1, 2, 8, 1'b0, 1'b0, 1'b0, 3};
        vecs[7]  = '{1'b1, 1'b0, 9'h000, 1, 2, 8, 1'b0, 1'b0, 1'b0, 3};
        vecs[8]  = '{1'b1, 1'b0, 9'h000, 3, 3, 0, 1'b1, 1'b1, 1'b0, 3};
        vecs[9]  = '{1'b1, 1'b0, 9'h000, 3, 3, 0, 1'b1, 1'b0, 1'b0, 3};
        vecs[10] = '{1'b1, 1'b0, 9'h000, 3, 3, 0, 1'b1, 1'b0, 1'b0, 3};
        vecs[11] = '{1'b1, 1'b0, 9'h000, 0, 3, 0, 1'b0, 1'b1, 1'b0, 3};
        vecs[12] = '{1'b0, 1'b1, 9'h000, 0, 3, 0, 1'b0, 1'b0, 1'b1, 3};
        vecs[13] = '{1'b0, 1'b1, 9'h003, 0, 3, 0, 1'b0, 1'b0, 1'b1, 3};
        vecs[14] = '{1'b1, 1'b0, 9'h000, 0, 3, 0, 1'b0, 1'b0, 1'b0, 3};
        vecs[15] = '{1'b0, 1'b1, 9'h008, 3, 3, 0, 1'b1, 1'b1, 1'b0, 3};
        vecs[16] = '{1'b0, 1'b0, 9'h000, 3, 3, 0, 1'b1, 1'b0, 1'b0, 3};

        #3;
        model_reset();
        model_check();
        @(posedge CLOCK_50);
        #1;
        RESET = 1'b0;

        // Directed table: single call to floor 3, door dwell, rejected strobes.
        for (int v = 0; v < 17; v++) begin
            cycle(vecs[v].tk, vecs[v].stb, vecs[v].oh);
            check($sformatf("vec%0d_state", v), 32'(state), 32'(vecs[v].st));
            check($sformatf("vec%0d_floor", v), 32'(cur_floor), 32'(vecs[v].fl));
            check($sformatf("vec%0d_pending", v), 32'(pending), 32'(vecs[v].pd));
            check($sformatf("vec%0d_door", v), 32'(door_open), 32'(vecs[v].dr));
            check($sformatf("vec%0d_chg", v), 32'(state_changed), 32'(vecs[v].ch));
            check($sformatf("vec%0d_err", v), 32'(req_err), 32'(vecs[v].er));
            check($sformatf("vec%0d_target", v), 32'(target_floor), 32'(vecs[v].tg));
        end

        // Calls 5 then 2 while rising from 0: stop at 2 first.
        do_reset("s2_rst");
        cycle(1'b0, 1'b1, NF'(1) << 5);
        cycle(1'b1, 1'b0, '0);
        cycle(1'b0, 1'b1, NF'(1) << 2);
        run_until_idle("s2", dn_tgt);
        s0 = (stops.size() > 0) ? stops[0] : -1;
        s1 = (stops.size() > 1) ? stops[1] : -1;
        check("s2_nstops", 32'(stops.size()), 32'd2);
        check("s2_stop0", 32'(s0), 32'd2);
        check("s2_stop1", 32'(s1), 32'd5);
        check("s2_final_floor", 32'(cur_floor), 32'd5);

        // Rising past 4 toward 6, then a call for 1 behind the car.
        do_reset("s3_rst");
        cycle(1'b0, 1'b1, NF'(1) << 6);
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            cycle(1'b1, 1'b0, '0);
            if (cur_floor == FW'(4)) begin
                ok = 1'b1;
                break;
            end
        end
        check("s3_reach4", 32'(ok), 32'd1);
        check("s3_state_up", 32'(state), 32'd1);
        cycle(1'b0, 1'b1, NF'(1) << 1);
        check("s3_target_up", 32'(target_floor), 32'd6);
        run_until_idle("s3", dn_tgt);
        s0 = (stops.size() > 0) ? stops[0] : -1;
        s1 = (stops.size() > 1) ? stops[1] : -1;
        check("s3_stop0", 32'(s0), 32'd6);
        check("s3_stop1", 32'(s1), 32'd1);
        check("s3_target_down", 32'(dn_tgt), 32'd1);

        // Re-call the current floor during the door dwell restarts the dwell.
        do_reset("s5_rst");
        cycle(1'b0, 1'b1, NF'(1) << 2);
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            cycle(1'b1, 1'b0, '0);
            if (door_open) begin
                ok = 1'b1;
                break;
            end
        end
        check("s5_door_reached", 32'(ok), 32'd1);
        check("s5_floor", 32'(cur_floor), 32'd2);
        cycle(1'b1, 1'b0, '0);
        cycle(1'b1, 1'b1, NF'(1) << 2);
        check("s5_restart_door", 32'(door_open), 32'd1);
        check("s5_restart_nochg", 32'(state_changed), 32'd0);
        check("s5_pending2", 32'(pending[2]), 32'd0);
        cycle(1'b1, 1'b0, '0);
        check("s5_open1", 32'(door_open), 32'd1);
        cycle(1'b1, 1'b0, '0);
        check("s5_open2", 32'(door_open), 32'd1);
        cycle(1'b1, 1'b0, '0);
        check("s5_closed", 32'(door_open), 32'd0);
        check("s5_idle", 32'(state), 32'd0);

        // Arrival at 7 with a simultaneous strobe for 7, then reset mid-leg.
        do_reset("s6_rst");
        cycle(1'b0, 1'b1, NF'(1) << 7);
        ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (m_state == 1 && m_floor == 6 && m_left == 1) begin
                ok = 1'b1;
                break;
            end
            cycle(1'b1, 1'b0, '0);
        end
        check("s6_approach", 32'(ok), 32'd1);
        cycle(1'b1, 1'b1, NF'(1) << 7);
        check("s6_floor7", 32'(cur_floor), 32'd7);
        check("s6_pending7", 32'(pending[7]), 32'd0);
        check("s6_door", 32'(state), 32'd3);
        cycle(1'b0, 1'b1, NF'(1) << 8);
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            cycle(1'b1, 1'b0, '0);
            if (state == 2'd1) begin
                ok = 1'b1;
                break;
            end
        end
        check("s6_up_again", 32'(ok), 32'd1);
        cycle(1'b1, 1'b0, '0);
        do_reset("s6_midleg");
        check("s6_door_after_rst", 32'(door_open), 32'd0);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r == 0) oh = '0;
            else if (r == 1) oh = NF'($urandom);
            else oh = NF'(1) << $urandom_range(0, NF - 1);
            cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0), oh);
            if ($urandom_range(0, 499) == 0) do_reset("rnd_rst");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/smartlift_scheduler.md
Name: smartlift_scheduler

Overview:
- Multi-request floor scheduler for the smartlift elevator. It replaces the single-target "s" register with a pending-call set over NFLOORS floors, serviced in SCAN order.
- Sequences car movement, floor arrival and door dwell on a slow step tick from the existing prescaler.
- Drives the current-floor, state and door outputs consumed by the HEX, LED and LCD logic.

Parameters:
- NFLOORS, 9: number of floors (0..NFLOORS-1); one-hot request width.
- FLOOR_W, 4: width of floor index outputs; must satisfy 2^FLOOR_W >= NFLOORS.
- FLOOR_TICKS, 2: ticks spent travelling between adjacent floors (>=1).
- DOOR_TICKS, 3: ticks the door stays open at a serviced floor (>=1).

Ports:
- CLOCK_50  in  1  system clock; single clock domain.
- RESET  in  1  asynchronous, active-high reset.
- tick  in  1  one-cycle step enable from the prescaler; all timing advances only on tick.
- req_strobe  in  1  one-cycle call pulse, already debounced and synchronised (from KEY0).
- req_onehot  in  NFLOORS  requested floor, one-hot (from SW).
- cur_floor  out  FLOOR_W  floor the car is at or last passed.
- target_floor  out  FLOOR_W  next floor to be serviced; equals cur_floor when nothing is pending.
- state  out  2  0=IDLE (parado), 1=UP (subindo), 2=DOWN (descendo), 3=DOOR.
- pending  out  NFLOORS  outstanding calls, one bit per floor.
- door_open  out  1  high while state==DOOR (green LED); moving = ~door_open & state!=IDLE (red LED).
- state_changed  out  1  one-cycle pulse whenever state changes (drives LCD refresh).
- req_err  out  1  one-cycle pulse when a strobed request is rejected.

Behaviour:
- Reset, asynchronous: cur_floor=0, state=IDLE, pending=0, dir_up=1, tick counter=0, state_changed=0, req_err=0, door_open=0.
- Request capture happens on any CLOCK_50 cycle with req_strobe=1, independent of tick. The pending bit is visible the next cycle.
  - req_onehot zero or multi-hot: reject, pulse req_err next cycle, pending unchanged.
  - Request for cur_floor while IDLE or DOOR: do not set pending. Enter or restart DOOR with its counter reset.
  - Request for cur_floor while UP or DOWN: set the pending bit; it is served on a later pass.
  - Request already pending: no change.
- Direction logic: any_above and any_below are computed from pending relative to cur_floor.
- The state machine evaluates only on cycles with tick=1. The counter cnt counts ticks within UP, DOWN and DOOR.
  - IDLE: if any_above and (dir_up or !any_below), go UP with dir_up=1. Else if any_below, go DOWN with dir_up=0. Else stay IDLE.
  - UP: cnt increments. At cnt==FLOOR_TICKS-1, cur_floor increments and cnt=0. If the new floor's pending bit is set, clear it and go DOOR. If no pending floor remains above, go DOOR only if that floor was pending, else IDLE.
  - DOWN: mirrors UP with decrement.
  - DOOR: cnt increments. At cnt==DOOR_TICKS-1, go IDLE with cnt=0. IDLE then re-evaluates on the next tick.
- Bounds: cur_floor never exceeds NFLOORS-1 or goes below 0. UP and DOWN are entered only when a pending bit exists in that direction, so saturation is an assertion, not a runtime case.
- Simultaneous events:
  - Strobe for the floor being arrived at in the same cycle: clear wins. The call is serviced and pending stays 0 for that bit.
  - Strobe for any other floor is merged with the clear.
- target_floor, combinational from registered state:
  - UP: nearest pending above.
  - DOWN: nearest pending below.
  - IDLE or DOOR: the floor the IDLE rule would choose next, else cur_floor.
- state_changed: registered compare of state against its previous value; exactly one pulse per transition.
- RESET mid-travel: immediate return to floor 0, IDLE; all calls dropped.

Decomposition:
- smartlift_pkg holds:
  - state encodings ST_IDLE=0, ST_UP=1, ST_DOWN=2, ST_DOOR=3, numerically matching the LCD's parado/subindo/descendo.
  - NFLOORS and FLOOR_W defaults.
  - A function onehot_valid.
- Sub-module smartlift_req_scan: combinational. Inputs are pending and cur_floor; outputs are any_above, any_below, near_above and near_below.
- The scheduler FSM, counters and request register stay in smartlift_scheduler.

Test Plan:
- Reset then strobe req_onehot=9'b000001000 -> pending=0x008 next cycle. After the first tick, state=UP and state_changed pulses once. cur_floor reaches 3 after 6 ticks (FLOOR_TICKS=2). Then door_open=1, pending=0, DOOR for 3 ticks, then IDLE.
- At floor 0, strobe floors 5 then 2 while moving up -> stops at 2 (DOOR), then 5. Afterwards pending=0 and cur_floor=5.
- At floor 4 going UP with pending {6}, strobe floor 1 -> services 6, then DOWN to 1. target_floor reads 6 then 1.
- Strobe req_onehot=0 and then 9'b000000011 -> req_err pulses twice, pending unchanged, state unchanged.
- Car in DOOR at floor 2, strobe floor 2 on the second DOOR tick -> DOOR counter restarts, 3 more ticks open, pending bit 2 stays 0.
- Arrival tick at floor 7 coincident with strobe floor 7 -> pending bit 7=0 after the cycle and DOOR entered. Assert RESET during the next UP leg -> cur_floor=0, state=IDLE, pending=0 immediately.
